// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan scheduler: FSM states, segment patterns,
// digit positions, saturation values and the double-dabble step.
package ssd_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CONV_SCORE = 3'd1;
  localparam logic [2:0] ST_CONV_POWER = 3'd2;
  localparam logic [2:0] ST_CONV_ANGLE = 3'd3;
  localparam logic [2:0] ST_COMMIT     = 3'd4;

  // Active-low segments {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b0000001;

  localparam int SCORE_MSD_IDX = 0;
  localparam int SCORE_LSD_IDX = 3;
  localparam int POWER_MSD_IDX = 4;
  localparam int POWER_LSD_IDX = 5;
  localparam int ANGLE_MSD_IDX = 6;
  localparam int ANGLE_LSD_IDX = 7;

  // Saturation limits 9999 and 99, held directly in BCD form
  localparam logic [15:0] SCORE_SAT_BCD = 16'h9999;
  localparam logic [7:0]  FIELD_SAT_BCD = 8'h99;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return SEG_ZERO;
    endcase
  endfunction

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit
  function automatic logic [19:0] dd_step(input logic [19:0] bcd, input logic bit_in);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[18:0], bit_in};
  endfunction

  // A nonzero ten-thousands digit means the value exceeds 9999
  function automatic logic [15:0] sat_score_bcd(input logic [19:0] bcd);
    return (bcd[19:16] != 4'd0) ? SCORE_SAT_BCD : bcd[15:0];
  endfunction

  // Any nonzero digit above tens means the value exceeds 99
  function automatic logic [7:0] sat_field_bcd(input logic [19:0] bcd);
    return (bcd[19:8] != 12'd0) ? FIELD_SAT_BCD : bcd[7:0];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit to 5-digit BCD converter; done pulses 16 cycles after start.
module bin2bcd_seq
  import ssd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [15:0] shreg;
  logic [3:0]  steps_left;

  // The first iteration happens on the start edge, the remaining 15 on the following edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      steps_left <= '0;
      bcd        <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        bcd        <= dd_step(20'd0, bin[15]);
        shreg      <= {bin[14:0], 1'b0};
        steps_left <= 4'd15;
      end else if (steps_left != 4'd0) begin
        bcd        <= dd_step(bcd, shreg[15]);
        shreg      <= {shreg[14:0], 1'b0};
        steps_left <= steps_left - 4'd1;
        done       <= (steps_left == 4'd1);
      end
    end
  end

endmodule

// File: rtl/ssd_scan_scheduler.sv
// 8-digit seven-segment scan scheduler with a shared BCD converter and atomic bank commit.
// Leading-zero blanking is enabled by defining SSD_LZ_BLANK_EN.
//  state      | meaning
//  IDLE       | display scanning, waiting for load or frame wrap
//  CONV_SCORE | converting sampled score
//  CONV_POWER | converting sampled power
//  CONV_ANGLE | converting sampled angle
//  COMMIT     | copy staged digits into the display bank
module ssd_scan_scheduler
  import ssd_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score_in,
  input  logic [7:0]  power_in,
  input  logic [7:0]  angle_in,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  anode,
  output logic [6:0]  ssd_out
);

  localparam int CNT_W = REFRESH_BITS + 3;

  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       scan_idx;
  logic             frame_wrap;
  logic             start_req;
  logic [2:0]       state;
  logic             conv_first;
  logic             conv_done;
  logic [15:0]      conv_bin;
  logic [19:0]      conv_bcd;
  logic [15:0]      samp_score;
  logic [7:0]       samp_power;
  logic [7:0]       samp_angle;
  logic [15:0]      stage_score;
  logic [7:0]       stage_power;
  logic [7:0]       stage_angle;
  logic [31:0]      bank;
  logic [3:0]       digits [8];
  logic [3:0]       cur_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scan_cnt <= '0;
    else        scan_cnt <= scan_cnt + CNT_W'(1);
  end

  assign scan_idx   = scan_cnt[CNT_W-1 -: 3];
  assign frame_wrap = &scan_cnt;
  assign start_req  = (state == ST_IDLE) && (load || frame_wrap);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    case (state)
      ST_CONV_SCORE: conv_bin = samp_score;
      ST_CONV_POWER: conv_bin = {8'h00, samp_power};
      ST_CONV_ANGLE: conv_bin = {8'h00, samp_angle};
      default:       conv_bin = 16'h0000;
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_first),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      conv_first  <= 1'b0;
      samp_score  <= '0;
      samp_power  <= '0;
      samp_angle  <= '0;
      stage_score <= '0;
      stage_power <= '0;
      stage_angle <= '0;
      bank        <= '0;
    end else begin
      conv_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            samp_score <= score_in;
            samp_power <= power_in;
            samp_angle <= angle_in;
            state      <= ST_CONV_SCORE;
            conv_first <= 1'b1;
          end
        end
        ST_CONV_SCORE: begin
          if (conv_done) begin
            stage_score <= sat_score_bcd(conv_bcd);
            state       <= ST_CONV_POWER;
            conv_first  <= 1'b1;
          end
        end
        ST_CONV_POWER: begin
          if (conv_done) begin
            stage_power <= sat_field_bcd(conv_bcd);
            state       <= ST_CONV_ANGLE;
            conv_first  <= 1'b1;
          end
        end
        ST_CONV_ANGLE: begin
          if (conv_done) begin
            stage_angle <= sat_field_bcd(conv_bcd);
            state       <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          bank  <= {stage_score, stage_power, stage_angle};
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Digit 0 (score thousands) sits in the top nibble of the bank
  always_comb begin
    for (int i = 0; i < 8; i++) digits[i] = bank[31-4*i -: 4];
  end

  assign cur_digit = digits[scan_idx];
  assign anode     = ~(8'h80 >> scan_idx);

`ifdef SSD_LZ_BLANK_EN
  logic [7:0] blank;

  // A digit blanks only while it and everything above it in its field is zero; units never blank
  always_comb begin
    blank                  = 8'h00;
    blank[SCORE_MSD_IDX]   = (digits[SCORE_MSD_IDX] == 4'd0);
    blank[SCORE_MSD_IDX+1] = blank[SCORE_MSD_IDX] && (digits[SCORE_MSD_IDX+1] == 4'd0);
    blank[SCORE_MSD_IDX+2] = blank[SCORE_MSD_IDX+1] && (digits[SCORE_MSD_IDX+2] == 4'd0);
    blank[POWER_MSD_IDX]   = (digits[POWER_MSD_IDX] == 4'd0);
    blank[ANGLE_MSD_IDX]   = (digits[ANGLE_MSD_IDX] == 4'd0);
    blank[SCORE_LSD_IDX]   = 1'b0;
    blank[POWER_LSD_IDX]   = 1'b0;
    blank[ANGLE_LSD_IDX]   = 1'b0;
  end

  assign ssd_out = blank[scan_idx] ? SEG_BLANK : seg_decode(cur_digit);
`else
  assign ssd_out = seg_decode(cur_digit);
`endif

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler: frame-level reference model compared every cycle, plus literal digit checks.
module tb_ssd_scan_scheduler;

  localparam int RB       = 2;
  localparam int DWELL    = 1 << RB;
  localparam int FRAME    = 8 * DWELL;
  localparam int CONV_LEN = 52;
`ifdef SSD_LZ_BLANK_EN
  localparam logic [6:0] LEAD_ZERO = 7'b1111111;
`else
  localparam logic [6:0] LEAD_ZERO = 7'b0000001;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] score_in = '0;
  logic [7:0]  power_in = '0;
  logic [7:0]  angle_in = '0;
  logic        busy;
  logic [7:0]  anode;
  logic [6:0]  ssd_out;

  int checks = 0;
  int failures = 0;

  // reference model state: scan position, cycles of conversion left, sampled and displayed values
  int m_cnt = 0, m_rem = 0;
  int m_sc = 0, m_pw = 0, m_an = 0;
  int b_sc = 0, b_pw = 0, b_an = 0;
  logic [6:0] got [8];
  int blen;

  always #5 clk = ~clk;

  ssd_scan_scheduler #(.REFRESH_BITS(RB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .score_in (score_in),
    .power_in (power_in),
    .angle_in (angle_in),
    .load     (load),
    .busy     (busy),
    .anode    (anode),
    .ssd_out  (ssd_out)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input int sc, input int pw, input int an);
    int v, pos;
    if (idx <= 3)      begin v = sc; pos = 3 - idx; end
    else if (idx <= 5) begin v = pw; pos = 5 - idx; end
    else               begin v = an; pos = 7 - idx; end
`ifdef SSD_LZ_BLANK_EN
    if (pos > 0 && v < pow10(pos)) return 7'b1111111;
`endif
    return seg_of((v / pow10(pos)) % 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_rem = 0;
      b_sc = 0; b_pw = 0; b_an = 0;
    end else begin
      if (m_rem == 0) begin
        if (load || m_cnt == FRAME - 1) begin
          m_sc = int'(score_in); m_pw = int'(power_in); m_an = int'(angle_in);
          m_rem = CONV_LEN;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          b_sc = (m_sc > 9999) ? 9999 : m_sc;
          b_pw = (m_pw > 99) ? 99 : m_pw;
          b_an = (m_an > 99) ? 99 : m_an;
        end
      end
      m_cnt = (m_cnt + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    logic [7:0] an_exp;
    if (rst_n) begin
      an_exp = ~(8'h80 >> (m_cnt / DWELL));
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("anode", 32'(anode), 32'(an_exp));
      chk("ssd_out", 32'(ssd_out), 32'(exp_seg(m_cnt / DWELL, b_sc, b_pw, b_an)));
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (m_rem != 0 && n < 200) begin @(negedge clk); n++; end
    if (m_rem != 0) timeout_fail("wait_idle");
  endtask

  task automatic do_load(input int s, input int p, input int a);
    wait_idle();
    score_in = 16'(s); power_in = 8'(p); angle_in = 8'(a);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
  endtask

  task automatic capture_frame();
    for (int n = 0; n < FRAME; n++) begin
      got[m_cnt / DWELL] = ssd_out;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0] lit [8];
    int n;
    lit[0] = 7'b1001111; lit[1] = 7'b0010010; lit[2] = 7'b0000110; lit[3] = 7'b1001100;
    lit[4] = 7'b0100100; lit[5] = 7'b0100000; lit[6] = 7'b0001111; lit[7] = 7'b0000000;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_anode", 32'(anode), 32'(8'b0111_1111));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_ssd", 32'(ssd_out), 32'(LEAD_ZERO));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1234 / 56 / 78 scans as 1..8
    do_load(1234, 56, 78);
    count_busy(blen);
    chk("t2_busy_len", 32'(blen), 32'(52));
    capture_frame();
    for (int k = 0; k < 8; k++) chk($sformatf("t2_digit%0d", k), 32'(got[k]), 32'(lit[k]));

    // saturation
    do_load(65535, 200, 100);
    count_busy(blen);
    chk("t3_busy_len", 32'(blen), 32'(52));
    capture_frame();
    chk("t3_digit0", 32'(got[0]), 32'(7'b0000100));
    chk("t3_digit3", 32'(got[3]), 32'(7'b0000100));
    chk("t3_digit4", 32'(got[4]), 32'(7'b0000100));
    chk("t3_digit7", 32'(got[7]), 32'(7'b0000100));

    // inputs change and load repeats mid-conversion
    do_load(4321, 12, 34);
    repeat (4) @(negedge clk);
    score_in = 16'd8888; power_in = 8'd77; angle_in = 8'd66;
    repeat (5) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    count_busy(blen);
    chk("t4_busy_rest", 32'(blen), 32'(42));
    capture_frame();
    chk("t4_digit0", 32'(got[0]), 32'(7'b1001100));
    chk("t4_digit3", 32'(got[3]), 32'(7'b1001111));
    chk("t4_digit5", 32'(got[5]), 32'(7'b0010010));
    chk("t4_digit6", 32'(got[6]), 32'(7'b0000110));
    chk("t4_digit7", 32'(got[7]), 32'(7'b1001100));

    // load coinciding with the frame wrap
    wait_idle();
    n = 0;
    while (!(m_rem == 0 && m_cnt == FRAME - 1) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) timeout_fail("t5_wrap_wait");
    score_in = 16'd1000; power_in = 8'd9; angle_in = 8'd10;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    count_busy(blen);
    chk("t5_busy_len", 32'(blen), 32'(52));
    capture_frame();
    chk("t5_digit0", 32'(got[0]), 32'(7'b1001111));
    chk("t5_digit6", 32'(got[6]), 32'(7'b1001111));

    // reset in the middle of a conversion
    do_load(2222, 33, 44);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_anode", 32'(anode), 32'(8'b0111_1111));
    chk("t1_busy", 32'(busy), 32'(1'b0));
    chk("t1_ssd", 32'(ssd_out), 32'(LEAD_ZERO));
    @(negedge clk);
    #2 rst_n = 1'b1;
    capture_frame();
    chk("t1_digit3", 32'(got[3]), 32'(7'b0000001));
    chk("t1_digit7", 32'(got[7]), 32'(7'b0000001));

    // leading zeros
    do_load(7, 0, 5);
    count_busy(blen);
    capture_frame();
    chk("t6_digit0", 32'(got[0]), 32'(LEAD_ZERO));
    chk("t6_digit2", 32'(got[2]), 32'(LEAD_ZERO));
    chk("t6_digit3", 32'(got[3]), 32'(7'b0001111));
    chk("t6_digit4", 32'(got[4]), 32'(LEAD_ZERO));
    chk("t6_digit5", 32'(got[5]), 32'(7'b0000001));
    chk("t6_digit6", 32'(got[6]), 32'(LEAD_ZERO));
    chk("t6_digit7", 32'(got[7]), 32'(7'b0100100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
